cpu_clk_ctrl: RTL and testbench

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/clk_ctrl_pkg.sv | 12 +
 rtl/btn_debounce.sv | 66 ++++++
 rtl/cpu_clk_ctrl.sv | 94 +++++++++
 tb/tb_cpu_clk_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU clock controller: FSM state encoding and divider width.
package clk_ctrl_pkg;

   localparam int DIV_W = 32;

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Step button conditioning: 2-flop synchronizer, optional stability filter, rising-edge pulse.
// The stability filter is built only when CPU_CLK_CTRL_DEBOUNCE_EN is defined.
module btn_debounce #(
   parameter int DEB_CYCLES = 1048576
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic rise_o
);

   logic sync1_q, sync2_q, prev_q, lvl;

   if (DEB_CYCLES < 1) begin : g_deb_chk
      $error("btn_debounce: DEB_CYCLES must be at least 1");
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          deb_q, deb_d;

   // The counter only advances while the synchronized input disagrees with the accepted level.
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) deb_d = sync2_q;
         else                              cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         deb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         deb_q <= deb_d;
      end
   end

   assign lvl = deb_q;
`else
   assign lvl = sync2_q;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) prev_q <= 1'b0;
      else         prev_q <= lvl;
   end

   assign rise_o = lvl & ~prev_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: free-run divider, single-step and halt handling.
// Optional step-button debouncing is enabled with the CPU_CLK_CTRL_DEBOUNCE_EN macro.
module cpu_clk_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int FAST_DIV   = 2097152,
   parameter int SLOW_DIV   = 536870912,
   parameter int DEB_CYCLES = 1048576
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             RUN,
   input  logic             SW15,
   input  logic             STEP_BTN,
   input  logic             HALT_REQ,
   output logic             CPU_CE,
   output logic [1:0]       STATE,
   output logic             HALTED,
   output logic [DIV_W-1:0] CE_COUNT
);

   state_e           state_q;
   logic [DIV_W-1:0] div_q, ce_cnt_q, n_div;
   logic             ce_q, halted_q, sw_q, step_rise;

   if (FAST_DIV < 2 || SLOW_DIV < 2) begin : g_div_chk
      $error("cpu_clk_ctrl: FAST_DIV and SLOW_DIV must be at least 2");
   end

   btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_btn (
      .clk_i (CLK),
      .rst_ni(RST_N),
      .btn_i (STEP_BTN),
      .rise_o(step_rise)
   );

   assign n_div = SW15 ? DIV_W'(SLOW_DIV) : DIV_W'(FAST_DIV);

   // CE is registered, so each decision below shows up on CPU_CE one cycle after it is taken.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_HALT;
         div_q    <= '0;
         ce_cnt_q <= '0;
         ce_q     <= 1'b0;
         halted_q <= 1'b0;
         sw_q     <= 1'b0;
      end else begin
         sw_q     <= SW15;
         ce_q     <= 1'b0;
         ce_cnt_q <= ce_cnt_q + DIV_W'(ce_q);
         if (!RUN) halted_q <= 1'b0;
         case (state_q)
            ST_HALT: begin
               if (RUN && !HALT_REQ && !halted_q) begin
                  state_q <= ST_RUN;
                  div_q   <= '0;
               end else if (!RUN && step_rise) begin
                  state_q <= ST_STEP;
                  ce_q    <= 1'b1;
               end
            end
            ST_RUN: begin
               // A halt request outranks a coinciding divider terminal count.
               if (HALT_REQ) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
                  div_q    <= '0;
               end else if (!RUN) begin
                  state_q <= ST_HALT;
                  div_q   <= '0;
               end else if (SW15 != sw_q) begin
                  div_q <= '0;
               end else if (div_q == n_div - 1'b1) begin
                  div_q <= '0;
                  ce_q  <= 1'b1;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            ST_STEP: state_q <= ST_HALT;
            default: state_q <= ST_HALT;
         endcase
      end
   end

   assign CPU_CE   = ce_q;
   assign STATE    = state_q;
   assign HALTED   = halted_q;
   assign CE_COUNT = ce_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with FAST_DIV=4, SLOW_DIV=16, DEB_CYCLES=3.
module tb_cpu_clk_ctrl;

   localparam int FAST = 4;
   localparam int SLOW = 16;
   localparam int DEB  = 3;

   logic        CLK = 1'b0, RST_N = 1'b0, RUN = 1'b0, SW15 = 1'b0, STEP_BTN = 1'b0, HALT_REQ = 1'b0;
   logic        CPU_CE, HALTED;
   logic [1:0]  STATE;
   logic [31:0] CE_COUNT;

   int checks   = 0;
   int failures = 0;

   cpu_clk_ctrl #(
      .FAST_DIV  (FAST),
      .SLOW_DIV  (SLOW),
      .DEB_CYCLES(DEB)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .RUN     (RUN),
      .SW15    (SW15),
      .STEP_BTN(STEP_BTN),
      .HALT_REQ(HALT_REQ),
      .CPU_CE  (CPU_CE),
      .STATE   (STATE),
      .HALTED  (HALTED),
      .CE_COUNT(CE_COUNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode, cycles elapsed in the current period, and a sample history of the button.
   typedef struct packed {
      logic [1:0]  st;
      logic [31:0] phase;
      logic        ce;
      logic        halted;
      logic        sw;
      logic        lvl;
      logic        rise;
      logic [31:0] count;
      logic [15:0] h;
   } model_t;

   model_t mdl = '0;

   function automatic model_t next_model(model_t m, logic run, logic sw, logic btn, logic hreq);
      model_t n;
      int     per;
      logic   newlvl;
      n       = m;
      per     = sw ? SLOW : FAST;
      n.count = m.count + 32'(m.ce);
      n.ce    = 1'b0;
      if (m.st == 2'd0) begin
         if (run && !hreq && !m.halted) begin
            n.st    = 2'd1;
            n.phase = 0;
         end else if (!run && m.rise) begin
            n.st = 2'd2;
            n.ce = 1'b1;
         end
      end else if (m.st == 2'd1) begin
         if (hreq) begin
            n.st     = 2'd0;
            n.halted = 1'b1;
         end else if (!run) begin
            n.st = 2'd0;
         end else if (sw != m.sw) begin
            n.phase = 0;
         end else begin
            n.phase = m.phase + 1;
            if (n.phase == 32'(per)) begin
               n.ce    = 1'b1;
               n.phase = 0;
            end
         end
      end else begin
         n.st = 2'd0;
      end
      if (!run && !(m.st == 2'd1 && hreq)) n.halted = 1'b0;
      n.sw = sw;
`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
      begin
         logic all1, all0;
         all1 = 1'b1;
         all0 = 1'b1;
         for (int i = 1; i <= DEB; i++) begin
            all1 &= m.h[i];
            all0 &= ~m.h[i];
         end
         newlvl = all1 ? 1'b1 : (all0 ? 1'b0 : m.lvl);
      end
`else
      newlvl = m.h[0];
`endif
      n.rise = newlvl & ~m.lvl;
      n.lvl  = newlvl;
      n.h    = {m.h[14:0], btn};
      return n;
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) mdl <= '0;
      else        mdl <= next_model(mdl, RUN, SW15, STEP_BTN, HALT_REQ);
   end

   always @(negedge CLK) begin
      chk("model_ce", 32'(CPU_CE), 32'(mdl.ce));
      chk("model_state", 32'(STATE), 32'(mdl.st));
      chk("model_halted", 32'(HALTED), 32'(mdl.halted));
      chk("model_ce_count", CE_COUNT, mdl.count);
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Leaves the next rising edge as "edge 0" with the chosen RUN level applied.
   task automatic do_reset(input logic run_after);
      @(negedge CLK);
      #1;
      RST_N = 1'b0; RUN = 1'b0; SW15 = 1'b0; STEP_BTN = 1'b0; HALT_REQ = 1'b0;
      #1;
      chk("rst_ce", 32'(CPU_CE), 0);
      chk("rst_state", 32'(STATE), 0);
      chk("rst_halted", 32'(HALTED), 0);
      chk("rst_ce_count", CE_COUNT, 0);
      @(negedge CLK);
      @(negedge CLK);
      #1;
      RST_N = 1'b1;
      RUN   = run_after;
   endtask

   logic [7:0] tbl [0:14] = '{8'h38, 8'h2A, 8'h58, 8'h3C, 8'h48, 8'h10, 8'h22, 8'h60,
                              8'h22, 8'h88, 8'h49, 8'h38, 8'h20, 8'h42, 8'h60};

   initial begin
      int ce_seen;

      // Free run at the fast rate
      do_reset(1'b1);
      ce_seen = 0;
      for (int k = 0; k <= 13; k++) begin
         @(negedge CLK);
         ce_seen += int'(CPU_CE);
         if (k == 0) chk("s1_state_run", 32'(STATE), 1);
         if (k == 3) chk("s1_no_ce_early", 32'(CPU_CE), 0);
         if (k == 4 || k == 8 || k == 12) chk("s1_ce_pulse", 32'(CPU_CE), 1);
         if (k == 13) begin
            chk("s1_ce_count", CE_COUNT, 3);
            chk("s1_ce_total", 32'(ce_seen), 3);
         end
      end

      // Rate change mid-period
      do_reset(1'b1);
      ce_seen = 0;
      for (int k = 0; k <= 23; k++) begin
         @(negedge CLK);
         ce_seen += int'(CPU_CE);
         if (k == 4)  chk("s2_first_ce", 32'(CPU_CE), 1);
         if (k == 8)  chk("s2_no_ce_8", 32'(CPU_CE), 0);
         if (k == 21) chk("s2_no_ce_21", 32'(CPU_CE), 0);
         if (k == 22) chk("s2_slow_ce", 32'(CPU_CE), 1);
         if (k == 23) chk("s2_ce_total", 32'(ce_seen), 2);
         if (k == 5) begin
            #1;
            SW15 = 1'b1;
         end
      end

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
      // Glitch then a 5-cycle hold: only the held press becomes a step
      do_reset(1'b0);
      ce_seen = 0;
      for (int k = 0; k <= 20; k++) begin
         @(negedge CLK);
         ce_seen += int'(CPU_CE);
         if (k == 7)  chk("s3_state_before", 32'(STATE), 0);
         if (k == 8) begin
            chk("s3_step_ce", 32'(CPU_CE), 1);
            chk("s3_step_state", 32'(STATE), 2);
         end
         if (k == 9)  chk("s3_state_after", 32'(STATE), 0);
         if (k == 20) chk("s3_ce_total", 32'(ce_seen), 1);
         #1;
         STEP_BTN = (k == 0) || (k >= 2 && k <= 6);
      end
`else
      // Single-cycle press: synchronizer plus edge detect
      do_reset(1'b0);
      ce_seen = 0;
      for (int k = 0; k <= 10; k++) begin
         @(negedge CLK);
         ce_seen += int'(CPU_CE);
         if (k == 2) chk("s3_no_ce_2", 32'(CPU_CE), 0);
         if (k == 3) begin
            chk("s3_step_ce", 32'(CPU_CE), 1);
            chk("s3_step_state", 32'(STATE), 2);
         end
         if (k == 4)  chk("s3_state_after", 32'(STATE), 0);
         if (k == 10) chk("s3_ce_total", 32'(ce_seen), 1);
         #1;
         STEP_BTN = (k == 0);
      end
      // Held press gives exactly one step
      do_reset(1'b0);
      ce_seen = 0;
      for (int k = 0; k <= 12; k++) begin
         @(negedge CLK);
         ce_seen += int'(CPU_CE);
         if (k == 3)  chk("s3_hold_ce", 32'(CPU_CE), 1);
         if (k == 12) chk("s3_hold_total", 32'(ce_seen), 1);
         #1;
         STEP_BTN = (k <= 4);
      end
`endif

      // Halt request coinciding with the terminal count
      do_reset(1'b1);
      for (int k = 0; k <= 18; k++) begin
         @(negedge CLK);
         if (k == 4) begin
            chk("s4_no_ce", 32'(CPU_CE), 0);
            chk("s4_state_halt", 32'(STATE), 0);
            chk("s4_halted", 32'(HALTED), 1);
         end
         if (k == 10) begin
            chk("s4_no_restart", 32'(STATE), 0);
            chk("s4_still_halted", 32'(HALTED), 1);
         end
         if (k == 11) chk("s4_halted_cleared", 32'(HALTED), 0);
         if (k == 12) chk("s4_rerun", 32'(STATE), 1);
         if (k == 16) begin
            chk("s4_rerun_ce", 32'(CPU_CE), 1);
            chk("s4_ce_count", CE_COUNT, 0);
         end
         #1;
         if (k == 3)  HALT_REQ = 1'b1;
         if (k == 4)  HALT_REQ = 1'b0;
         if (k == 10) RUN = 1'b0;
         if (k == 11) RUN = 1'b1;
      end

      // Reset pulse during RUN with divider at 2
      do_reset(1'b1);
      for (int k = 0; k <= 10; k++) @(negedge CLK);
      chk("s5_count_before", CE_COUNT, 2);
      #1;
      RST_N = 1'b0;
      #1;
      chk("s5_ce_rst", 32'(CPU_CE), 0);
      chk("s5_state_rst", 32'(STATE), 0);
      chk("s5_halted_rst", 32'(HALTED), 0);
      chk("s5_count_rst", CE_COUNT, 0);
      @(negedge CLK);
      #1;
      RST_N = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         @(negedge CLK);
         if (k == 3) chk("s5_no_early_ce", 32'(CPU_CE), 0);
         if (k == 4) chk("s5_ce_after_rst", 32'(CPU_CE), 1);
         if (k == 5) chk("s5_count_after", CE_COUNT, 1);
      end

      // Mixed directed sequence checked by the model alone
      do_reset(1'b0);
      foreach (tbl[i]) begin
         RUN      = tbl[i][3];
         SW15     = tbl[i][2];
         STEP_BTN = tbl[i][1];
         HALT_REQ = tbl[i][0];
         repeat (int'(tbl[i][7:4])) @(negedge CLK);
         #1;
      end
      repeat (4) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
